// File: rtl/apb_pkg.sv
// Shared APB definitions.
//   apb_state_e      : requester FSM states (IDLE / SETUP / ACCESS)
//   apb_prot_t       : 3-bit APB protection attribute type
//   APB_PROT_DEFAULT : protection value driven on every transfer
//   idx_w()          : width of an index into n items (never below 1)
//   MAX_REQ/MAX_REQ_W: largest supported client count and its index width
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef logic [2:0] apb_prot_t;

  localparam apb_prot_t APB_PROT_DEFAULT = 3'b000;

  // A single client still needs a 1-bit pointer/index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAX_REQ   = 8;
  localparam int MAX_REQ_W = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [PW-1:0] highest-priority index (must be < N)
//   grant [N-1:0]  one-hot grant, all zero when no request
//   any            at least one request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = apb_pkg::idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  // One extra bit so ptr + i never overflows before the wrap subtraction.
  logic [PW:0] w_sum;
  logic        w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      if (!w_found && req[w_sum[PW-1:0]]) begin
        grant[w_sum[PW-1:0]] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/apb_rr_requester.sv
// APB requester shared by NUM_REQ local clients via a round-robin arbiter.
// Each client issues one single-beat read or write; the block runs it
// through APB SETUP/ACCESS and returns rdata/error to that client only.
//
// Client side : req_valid/req_ready (one-hot), req_write, packed req_addr,
//               req_wdata, req_strb; rsp_valid (one-hot pulse), rsp_rdata,
//               rsp_err.
// APB side    : paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
//               pready, prdata, pslverr.
// Debug       : dbg_state exposes the FSM state.
//
// Handshake: a command transfers in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational and only rises in
// IDLE or in the ACCESS cycle that completes (pready=1 or timeout). A client
// must hold its fields while valid and not ready, and may drop valid before
// being granted. rsp_valid pulses for exactly one cycle per accepted command.
//
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that sees no
// pready for TIMEOUT_CYCLES cycles (rsp_err=1, rsp_rdata=0). Without it the
// ACCESS phase waits indefinitely.
module apb_rr_requester
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              pclk,
  input  logic                              presetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic [ADDR_WIDTH-1:0]             paddr,
  output logic                              psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [DATA_WIDTH-1:0]             pwdata,
  output logic [DATA_WIDTH/8-1:0]           pstrb,
  output apb_prot_t                         pprot,
  input  logic                              pready,
  input  logic [DATA_WIDTH-1:0]             prdata,
  input  logic                              pslverr,
  output apb_state_e                        dbg_state
);

  localparam int PW = idx_w(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  apb_state_e              r_state, w_next_state;
  logic [PW-1:0]           r_ptr, r_gnt_idx, w_next_ptr, w_arb_ptr, w_gnt_idx;
  logic [NUM_REQ-1:0]      r_gnt_vec, w_grant, r_rsp_valid;
  logic                    w_any, w_arb_en, w_done, w_accept, w_timeout;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_sel_addr;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_sel_wdata, r_rsp_rdata;
  logic [SW-1:0]           r_pstrb, w_sel_strb;
  logic                    r_pwrite, w_sel_write, r_rsp_err;

  // Pointer moves past the client just served; used directly in the
  // completion cycle so a back-to-back grant already sees the new order.
  assign w_next_ptr = (r_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
  assign w_arb_ptr  = w_done ? w_next_ptr : r_ptr;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (w_arb_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                        r_to_cnt <= '0;
    else if (r_state == SETUP)           r_to_cnt <= '0;
    else if (r_state == ACCESS && !pready) r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Fires on the wait cycle whose increment would reach TIMEOUT_CYCLES,
  // so the ACCESS phase lasts exactly TIMEOUT_CYCLES cycles. A pready in
  // that same cycle wins and completes normally.
  assign w_timeout = (r_state == ACCESS) && !pready &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // No abort path; the parameter only matters when the timeout is built in.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_next_state = r_state;
    w_arb_en     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb_en = 1'b1;
        if (w_any) w_next_state = SETUP;
      end
      SETUP:  w_next_state = ACCESS;
      ACCESS: begin
        if (pready || w_timeout) begin
          w_done       = 1'b1;
          w_arb_en     = 1'b1;
          w_next_state = w_any ? SETUP : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // No command may be accepted while reset is held.
    if (!presetn) w_arb_en = 1'b0;
  end

  assign w_accept  = w_arb_en & w_any;
  assign req_ready = w_arb_en ? w_grant : '0;

  always_comb begin
    w_gnt_idx   = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx   = PW'(i);
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_strb  = req_strb[i*SW +: SW];
        w_sel_write = req_write[i];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pwrite    <= 1'b0;
      r_gnt_idx   <= '0;
      r_gnt_vec   <= '0;
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_paddr   <= w_sel_addr;
        r_pwdata  <= w_sel_wdata;
        r_pstrb   <= w_sel_write ? w_sel_strb : '0;
        r_pwrite  <= w_sel_write;
        r_gnt_idx <= w_gnt_idx;
        r_gnt_vec <= w_grant;
      end
      if (w_done) begin
        r_ptr       <= w_next_ptr;
        r_rsp_valid <= r_gnt_vec;
        r_rsp_err   <= w_timeout | (pready & pslverr);
        r_rsp_rdata <= (r_pwrite || w_timeout) ? '0 : prdata;
      end else begin
        r_rsp_valid <= '0;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  // psel/penable decode straight from the state register so an async reset
  // drops them immediately.
  assign psel      = (r_state != IDLE);
  assign penable   = (r_state == ACCESS);
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign pprot     = APB_PROT_DEFAULT;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_apb_rr_requester.sv
// Bench for apb_rr_requester (NUM_REQ=2, 32-bit APB, TIMEOUT_CYCLES=8).
// A behavioural APB completer answers with configurable wait states, error
// and read data; expected responses are queued when commands are accepted
// and compared when rsp_valid pulses. Timeout scenario runs only when
// APB_TIMEOUT_EN is defined.
module tb_apb_rr_requester;
  import apb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = NR + 1 + DW;

  logic            pclk, presetn;
  logic [NR-1:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*4-1:0]  req_strb;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;
  logic [3:0]      pstrb;
  apb_prot_t       pprot;
  apb_state_e      dbg_state;

  int n_err = 0;
  int n_chk = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;

  int          cfg_wait   = 0;
  logic        cfg_err    = 1'b0;
  logic        cfg_fixed  = 1'b0;
  logic [31:0] cfg_rdata  = '0;
  logic        cfg_manual = 1'b0;
  int          wcnt       = 0;

  apb_rr_requester #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- APB completer model ----------------
  always @(posedge pclk) begin
    #1;
    if (!cfg_manual) begin
      if (presetn && psel && penable) begin
        if (wcnt < cfg_wait) begin
          pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_F00D; wcnt++;
        end else begin
          pready  = 1'b1;
          pslverr = cfg_err;
          prdata  = pwrite ? 32'hBAD0_BAD0 : (cfg_fixed ? cfg_rdata : rd_fn(paddr));
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_F00D; wcnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge pclk) begin
    if (presetn && rsp_valid != '0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got valid=%b err=%b rdata=%h, required no response",
                 rsp_valid, rsp_err, rsp_rdata);
      end else begin
        exp_v = exp_q.pop_front();
        if ({rsp_valid, rsp_err, rsp_rdata} !== exp_v) begin
          n_err++;
          $display("FAIL rsp_data: got valid=%b err=%b rdata=%h, required valid=%b err=%b rdata=%h",
                   rsp_valid, rsp_err, rsp_rdata, exp_v[EW-1 -: NR], exp_v[DW], exp_v[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Presents one command and waits (bounded) for its acceptance. Returns in
  // the cycle after acceptance (+1 after the edge) with valid dropped.
  task automatic issue(input int c, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input bit to_exp);
    bit ok;
    logic [NR-1:0] oh;
    step();
    req_valid[c] = 1'b1;
    req_write[c] = wr;
    req_addr[c*AW +: AW]  = a;
    req_wdata[c*DW +: DW] = wd;
    req_strb[c*4 +: 4]    = st;
    oh = 2'b01 << c;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (req_ready[c]) begin
        ok = 1'b1;
        if (to_exp)  exp_q.push_back({oh, 1'b1, 32'h0});
        else if (wr) exp_q.push_back({oh, cfg_err, 32'h0});
        else         exp_q.push_back({oh, cfg_err, cfg_fixed ? cfg_rdata : rd_fn(a)});
        break;
      end
      step();
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: client %0d never saw req_ready, required acceptance", c);
    end
    step();
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      #2;
      if (rsp_valid != '0) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL rsp_timeout: no rsp_valid within 40 cycles, required a response");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    presetn = 1'b0;
    req_valid = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (3) @(posedge pclk);
    #3;
    n_chk++;
    if ({psel, penable, req_ready, rsp_valid, rsp_err, pwrite} !== 8'b0 ||
        paddr !== '0 || pwdata !== '0 || pstrb !== '0 || rsp_rdata !== '0 ||
        pprot !== 3'b000 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got psel=%b penable=%b ready=%b rsp=%b paddr=%h state=%0d, required all zero/IDLE",
               psel, penable, req_ready, rsp_valid, paddr, dbg_state);
    end
    req_valid = '0;
    step();
    presetn = 1'b1;
  endtask

  task automatic test_single_read();
    cfg_fixed = 1'b1; cfg_rdata = 32'hDEAD_BEEF;
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    #2;
    n_chk++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h10 || pwrite !== 1'b0 || pstrb !== 4'h0) begin
      n_err++;
      $display("FAIL t1_setup: got psel=%b penable=%b paddr=%h pwrite=%b pstrb=%h, required 1 0 00000010 0 0",
               psel, penable, paddr, pwrite, pstrb);
    end
    step(); #2;
    n_chk++;
    if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL t1_access: got psel=%b penable=%b rsp=%b, required 1 1 00", psel, penable, rsp_valid);
    end
    step(); #2;
    n_chk++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL t1_rsp: got rsp=%b rdata=%h err=%b, required 01 deadbeef 0", rsp_valid, rsp_rdata, rsp_err);
    end
    cfg_fixed = 1'b0;
  endtask

  task automatic test_write_wait();
    int  acc;
    bit  stable;
    acc = 0; stable = 1'b1;
    cfg_wait = 3;
    issue(1, 1'b1, 32'h20, 32'h1234, 4'b0011, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(); #2;
      if (rsp_valid != '0) break;
      if (penable) begin
        acc++;
        if (paddr !== 32'h20 || pwdata !== 32'h1234 || pstrb !== 4'b0011 || pwrite !== 1'b1 || psel !== 1'b1)
          stable = 1'b0;
      end
    end
    n_chk++;
    if (acc != 4 || !stable) begin
      n_err++;
      $display("FAIL t2_access: got %0d access cycles stable=%b, required 4 stable", acc, stable);
    end
    n_chk++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL t2_rsp: got rsp=%b err=%b, required 10 0", rsp_valid, rsp_err);
    end
    step(); #2;
    n_chk++;
    if (rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL t2_pulse: got rsp=%b one cycle later, required 00", rsp_valid);
    end
    cfg_wait = 0;
  endtask

  task automatic test_back_to_back();
    int ng, gap;
    int order[4];
    int when[4];
    logic [31:0] a0, a1;
    ng = 0; gap = 0;
    a0 = 32'h100; a1 = 32'h200;
    step();
    req_valid = 2'b11; req_write = 2'b10;
    req_addr = {a1, a0}; req_wdata = {32'hA1A1_0000, 32'h0}; req_strb = {4'hF, 4'hF};
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      #2;
      if (ng >= 1 && !psel) gap = 1;
      if (req_ready != '0) begin
        order[ng] = req_ready[1] ? 1 : 0;
        when[ng]  = cyc;
        if (req_ready[1]) exp_q.push_back({2'b10, 1'b0, 32'h0});
        else              exp_q.push_back({2'b01, 1'b0, rd_fn(a0)});
        ng++;
      end
      step();
      if (order[ng-1] == 0 && ng > 0 && when[ng-1] == cyc) begin a0 = a0 + 4; req_addr[31:0] = a0; end
      if (order[ng-1] == 1 && ng > 0 && when[ng-1] == cyc) begin a1 = a1 + 4; req_addr[63:32] = a1; end
      if (ng == 4) req_valid = '0;
    end
    n_chk++;
    if (ng != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      n_err++;
      $display("FAIL t3_order: got %0d grants %0d%0d%0d%0d, required 4 grants 0101",
               ng, order[0], order[1], order[2], order[3]);
    end
    n_chk++;
    if (ng != 4 || gap != 0 || when[1] - when[0] != 2 || when[2] - when[1] != 2 || when[3] - when[2] != 2) begin
      n_err++;
      $display("FAIL t3_b2b: got gap=%0d spacing %0d/%0d/%0d, required no IDLE and spacing 2",
               gap, when[1] - when[0], when[2] - when[1], when[3] - when[2]);
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
  endtask

  task automatic test_slverr();
    cfg_err = 1'b1;
    issue(1, 1'b0, 32'h44, 32'h0, 4'hF, 1'b0);
    wait_rsp();
    n_chk++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b1) begin
      n_err++;
      $display("FAIL t4_err: got rsp=%b err=%b, required 10 1", rsp_valid, rsp_err);
    end
    cfg_err = 1'b0;
    issue(0, 1'b0, 32'h48, 32'h0, 4'hF, 1'b0);
    wait_rsp();
    n_chk++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== rd_fn(32'h48)) begin
      n_err++;
      $display("FAIL t4_next: got rsp=%b err=%b rdata=%h, required 01 0 %h",
               rsp_valid, rsp_err, rsp_rdata, rd_fn(32'h48));
    end
  endtask

  task automatic test_reset_mid();
    cfg_wait = 5;
    issue(1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0);
    step(); #2;
    n_chk++;
    if (penable !== 1'b1) begin
      n_err++;
      $display("FAIL t5_in_access: got penable=%b, required 1", penable);
    end
    #1 presetn = 1'b0;
    #1;
    n_chk++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL t5_async: got psel=%b penable=%b rsp=%b, required 0 0 00", psel, penable, rsp_valid);
    end
    exp_q.delete();
    cfg_wait = 0;
    step(); step();
    presetn = 1'b1;
    step();
    req_valid = 2'b11; req_write = 2'b00;
    req_addr = {32'h94, 32'h90};
    #2;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL t5_first_grant: got req_ready=%b, required 01", req_ready);
    end
    if (req_ready[0]) exp_q.push_back({2'b01, 1'b0, rd_fn(32'h90)});
    step();
    req_valid = 2'b00;
    wait_rsp();
    n_chk++;
    if (rsp_valid !== 2'b01) begin
      n_err++;
      $display("FAIL t5_rsp: got rsp=%b, required 01", rsp_valid);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    acc = 0;
    cfg_wait = 1000;
    issue(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b1);
    for (int k = 0; k < 40; k++) begin
      step(); #2;
      if (rsp_valid != '0) break;
      if (penable) acc++;
    end
    n_chk++;
    if (acc != 8 || rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin
      n_err++;
      $display("FAIL t6_abort: got acc=%0d rsp=%b err=%b rdata=%h psel=%b, required 8 01 1 0 0",
               acc, rsp_valid, rsp_err, rsp_rdata, psel);
    end
    cfg_manual = 1'b1;
    step();
    pready = 1'b1; prdata = 32'h1111_2222;
    #2;
    step();
    pready = 1'b0;
    #2;
    n_chk++;
    if (rsp_valid !== 2'b00 || psel !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL t6_late_pready: got rsp=%b psel=%b state=%0d, required 00 0 IDLE",
               rsp_valid, psel, dbg_state);
    end
    cfg_manual = 1'b0;
    cfg_wait = 0;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_slverr();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) step();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_rr_requester.md
Name: apb_rr_requester

Overview:
- APB requester (master) shared by NUM_REQ local clients through a round-robin arbiter.
- Each client issues one single-beat read or write command; the block sequences it through APB SETUP/ACCESS phases and returns rdata/error to that client only.
- Sits between on-chip control agents (CPU bridge, DMA config, debug) and an APB completer fabric.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (8/16/32)
TIMEOUT_CYCLES, 256, ACCESS cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
pclk  in  1  clock
presetn  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-client command valid
req_ready  out  NUM_REQ  per-client command accept, one-hot
req_write  in  NUM_REQ  1=write
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_strb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes
rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot
rsp_rdata  out  DATA_WIDTH  read data for the pulsing client
rsp_err  out  1  pslverr/timeout for the pulsing client
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes (forced 0 on reads)
pprot  out  3  fixed 3'b000
pready  in  1  APB ready
prdata  in  DATA_WIDTH  APB read data
pslverr  in  1  APB error

Behaviour:
- Reset (presetn low, async): state IDLE; psel, penable, req_ready, rsp_valid, rsp_err = 0; paddr, pwdata, pstrb, pwrite, rsp_rdata = 0; RR pointer = 0. Reset mid-transfer aborts immediately; no response is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, the arbiter grants the first requesting client at or after the RR pointer, wrapping at NUM_REQ-1 back to 0. req_ready[g] is asserted combinationally in this cycle. The command is registered onto the APB outputs. Next state SETUP.
- SETUP: psel=1, penable=0. Next state ACCESS unconditionally.
- ACCESS: psel=1, penable=1. APB outputs are held stable while pready=0.
- Completion (ACCESS with pready=1):
  - Next cycle: rsp_valid[g]=1 for one cycle; rsp_rdata = sampled prdata (0 for writes); rsp_err = pslverr.
  - RR pointer = (g+1) mod NUM_REQ.
  - If any req_valid is present in the completion cycle, arbitrate with the updated pointer, assert req_ready, and go directly to SETUP (back-to-back; psel stays 1, penable drops to 0). Otherwise go to IDLE.
- Grant latency from accept: SETUP +1 cycle, ACCESS +2 cycles, minimum rsp_valid +3 cycles.
- req_ready is never asserted while a transfer is in SETUP or ACCESS, except in the completion cycle.
- Clients must hold their request fields stable while req_valid=1 and req_ready=0.
- A client may drop req_valid before being granted without side effects.
- A client reasserting in the cycle its rsp_valid pulses is eligible; RR order still applies.
- Fairness: with all clients continuously requesting, grants cycle 0,1,…,NUM_REQ-1,0…

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: psel=penable=0 next cycle, rsp_valid[g]=1 with rsp_err=1 and rsp_rdata=0, then IDLE or arbitrate as on a normal completion.
  - A late pready after the abort is ignored.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_pkg: apb_state_e enum (IDLE/SETUP/ACCESS), apb_prot_t (3-bit) with the APB_PROT_DEFAULT constant, clog2-based width helper constants.
- Sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot grant, any), reused by later APB/AHB muxes.

Test Plan:
1. Single read, client 0, addr 0x10, pready=1 at the first ACCESS cycle, prdata=0xDEADBEEF -> psel at T+1, penable at T+2, rsp_valid=2'b01 at T+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Write with 3 wait states, client 1, addr 0x20, wdata 0x1234, strb 4'b0011 -> paddr, pwdata and pstrb stable for 4 ACCESS cycles; single rsp_valid[1] pulse; rsp_err=0.
3. Both clients requesting continuously, NUM_REQ=2 -> grant order 0,1,0,1; back-to-back transfers without an IDLE cycle between them.
4. pslverr=1 on a read from client 1 -> rsp_err=1 with rsp_valid[1]; the next transfer is unaffected.
5. presetn pulled low during ACCESS -> psel=penable=0 asynchronously, no rsp_valid, first grant after release goes to client 0.
6. APB_TIMEOUT_EN with TIMEOUT_CYCLES=8, pready held 0 -> abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0; a later pready has no effect.
